// File: rtl/dds_phase_ctrl.sv
// DDS phase accumulator and waveform-table address generator. It shares the
// single table RAM port between sample reads (RUN) and host writes (LOAD).
module dds_phase_ctrl #(
    parameter int PHASE_W  = 32,
    parameter int ADDR_W   = 12,
    parameter int SEG_W    = 10,
    parameter int WAVE_NUM = 3,
    parameter int DATA_W   = 8
) (
    input  logic               clka,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_update,
    input  logic [PHASE_W-1:0] fword,
    input  logic [SEG_W-1:0]   pword,
    input  logic [1:0]         wave_sel,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic               ram_ena,
    output logic               ram_wea,
    output logic [ADDR_W-1:0]  ram_addra,
    output logic [DATA_W-1:0]  ram_dina,
    input  logic [DATA_W-1:0]  ram_douta,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] TABLE_DEPTH = (ADDR_W+1)'(WAVE_NUM << SEG_W);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               start_pend_q, start_pend_d;

    logic [PHASE_W-1:0] fword_q, fword_d;
    logic [SEG_W-1:0]   pword_q, pword_d;
    logic [1:0]         wave_q, wave_d;

    logic               rd_d1_q, rd_d1_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;

    logic [SEG_W-1:0]   seg_idx;
    logic [ADDR_W-1:0]  run_addr;
    logic               wr_in_range;

    // Top SEG_W accumulator bits select the sample; the offset wraps inside the segment.
    assign seg_idx     = acc_q[PHASE_W-1 -: SEG_W] + pword_q;
    assign run_addr    = (ADDR_W'(wave_q) << SEG_W) | ADDR_W'(seg_idx);
    assign wr_in_range = ({1'b0, wr_addr} < TABLE_DEPTH);

    // Configuration shadow registers; an unpopulated segment number folds to 0.
    always_comb begin
        fword_d = fword_q;
        pword_d = pword_q;
        wave_d  = wave_q;
        if (cfg_update) begin
            fword_d = fword;
            pword_d = pword;
            wave_d  = (int'(wave_sel) >= WAVE_NUM) ? 2'd0 : wave_sel;
        end
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        start_pend_d = start_pend_q;
        wr_ack       = 1'b0;
        ram_ena      = 1'b0;
        ram_wea      = 1'b0;
        ram_addra    = '0;
        ram_dina     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d = ST_LOAD;
                    if (start) begin
                        start_pend_d = 1'b1;
                    end
                end else if (start || start_pend_q) begin
                    state_d      = ST_RUN;
                    acc_d        = '0;
                    start_pend_d = 1'b0;
                end
            end

            ST_LOAD: begin
                ram_ena   = wr_in_range;
                ram_wea   = wr_in_range;
                ram_addra = wr_addr;
                ram_dina  = wr_data;
                wr_ack    = 1'b1;
                state_d   = ST_IDLE;
            end

            ST_RUN: begin
                ram_ena   = 1'b1;
                ram_addra = run_addr;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + fword_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The RAM registers its read data, so samples trail the address by two edges.
    always_comb begin
        rd_d1_d      = (state_q == ST_RUN);
        dout_valid_d = rd_d1_q;
        dout_d       = rd_d1_q ? ram_douta : dout_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            start_pend_q <= 1'b0;
            fword_q      <= '0;
            pword_q      <= '0;
            wave_q       <= '0;
            rd_d1_q      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            start_pend_q <= start_pend_d;
            fword_q      <= fword_d;
            pword_q      <= pword_d;
            wave_q       <= wave_d;
            rd_d1_q      <= rd_d1_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Randomized bench for dds_phase_ctrl: a behavioural model predicts RAM port
// activity and queues expected samples; a monitor matches them against dout.
module tb_dds_phase_ctrl;

    localparam int DEPTH = 3072;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, cfg_update = 1'b0;
    logic [31:0] fword = '0;
    logic [9:0]  pword = '0;
    logic [1:0]  wave_sel = '0;
    logic        wr_req = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack, ram_ena, ram_wea, dout_valid, busy;
    logic [11:0] ram_addra;
    logic [7:0]  ram_dina, dout;
    logic [7:0]  ram_douta = '0;

    always #5 clka = ~clka;

    dds_phase_ctrl dut (
        .clka(clka), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_update(cfg_update), .fword(fword), .pword(pword), .wave_sel(wave_sel),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dina(ram_dina), .ram_douta(ram_douta),
        .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    // Table RAM: 3072 x 8, registered read.
    logic [7:0] ram [0:DEPTH-1];
    always @(posedge clka) begin
        if (ram_ena) begin
            if (ram_wea) ram[ram_addra] <= ram_dina;
            ram_douta <= ram[ram_addra];
        end
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: generator mode, phase, configuration and table contents.
    typedef enum {M_IDLE, M_RUN, M_LOAD} mode_t;
    mode_t       m_mode = M_IDLE;
    logic [31:0] m_phase = '0;
    logic [31:0] m_fword = '0;
    int          m_pword = 0;
    int          m_wave = 0;
    bit          m_pend = 1'b0;
    logic [7:0]  ref_mem [0:DEPTH-1];

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t sb_q[$];

    // Driver-side requested values for the next cycle.
    logic        d_start = 0, d_stop = 0, d_cfg = 0, d_wr_req = 0;
    logic [31:0] d_fword = '0;
    logic [9:0]  d_pword = '0;
    logic [1:0]  d_wave = '0;
    logic [11:0] d_wr_addr = '0;
    logic [7:0]  d_wr_data = '0;
    bit          saw_ack = 0;

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = '0; m_fword = '0; m_pword = 0; m_wave = 0; m_pend = 0;
        sb_q.delete();
    endtask

    task automatic check_port();
        int exp_addr;
        bit in_range;
        saw_ack = (m_mode == M_LOAD);
        case (m_mode)
            M_IDLE: begin
                check("idle_ena", ram_ena, 0);
                check("idle_wea", ram_wea, 0);
                check("idle_ack", wr_ack, 0);
                check("idle_busy", busy, 0);
            end
            M_RUN: begin
                exp_addr = m_wave * 1024 + (int'(m_phase >> 22) + m_pword) % 1024;
                check("run_ena", ram_ena, 1);
                check("run_wea", ram_wea, 0);
                check("run_ack", wr_ack, 0);
                check("run_busy", busy, 1);
                check("run_addr", ram_addra, exp_addr);
                sb_q.push_back('{ref_mem[exp_addr], cyc + 2});
            end
            M_LOAD: begin
                in_range = (int'(wr_addr) < DEPTH);
                check("load_ena", ram_ena, in_range);
                check("load_wea", ram_wea, in_range);
                check("load_ack", wr_ack, 1);
                check("load_busy", busy, 1);
                check("load_addr", ram_addra, wr_addr);
                check("load_din", ram_dina, wr_data);
            end
            default: ;
        endcase
    endtask

    task automatic model_advance();
        logic [31:0] step_w;
        step_w = m_fword;
        if (cfg_update) begin
            m_fword = fword;
            m_pword = int'(pword);
            m_wave  = (wave_sel == 2'd3) ? 0 : int'(wave_sel);
        end
        case (m_mode)
            M_IDLE: begin
                if (wr_req) begin
                    m_mode = M_LOAD;
                    if (start) m_pend = 1;
                end else if (start || m_pend) begin
                    m_mode = M_RUN; m_phase = '0; m_pend = 0;
                end
            end
            M_LOAD: begin
                if (int'(wr_addr) < DEPTH) ref_mem[wr_addr] = wr_data;
                m_mode = M_IDLE;
            end
            M_RUN: begin
                if (stop) m_mode = M_IDLE;
                else if (start) m_phase = '0;
                else m_phase = m_phase + step_w;
            end
            default: ;
        endcase
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model.
    task automatic step();
        @(negedge clka);
        start = d_start; stop = d_stop; cfg_update = d_cfg;
        fword = d_fword; pword = d_pword; wave_sel = d_wave;
        wr_req = d_wr_req; wr_addr = d_wr_addr; wr_data = d_wr_data;
        #1;
        check_port();
        model_advance();
        d_start = 0; d_stop = 0; d_cfg = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_cfg(input logic [31:0] f, input logic [9:0] p, input logic [1:0] w);
        d_cfg = 1; d_fword = f; d_pword = p; d_wave = w;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"}, ram_ena, 0);
        check({tag, "_wea"}, ram_wea, 0);
        check({tag, "_addr"}, ram_addra, 0);
        check({tag, "_din"}, ram_dina, 0);
        check({tag, "_ack"}, wr_ack, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_valid"}, dout_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: each expected sample must appear exactly at its due cycle.
    bit mon_due;
    always @(negedge clka) begin
        if (rst_n) begin
            mon_due = (sb_q.size() != 0) && (sb_q[0].due == cyc);
            check("dout_valid", dout_valid, mon_due);
            if (mon_due) begin
                if (dout_valid) check("dout", dout, sb_q[0].data);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clka);
        rst_n = 1'b1;

        // Fill the whole table through the host write path.
        for (int a = 0; a < DEPTH; a++) begin
            d_wr_req = 1; d_wr_addr = 12'(a); d_wr_data = 8'($urandom);
            run_cycles(2);
        end
        d_wr_req = 0;
        step();

        // Unit step through segment 0, including the wrap back to address 0.
        set_cfg(32'h0040_0000, 10'd0, 2'd0);
        d_start = 1; step();
        run_cycles(1030);
        d_stop = 1; step();
        run_cycles(4);

        // Step 2 in segment 1 starting at offset 512.
        set_cfg(32'h0080_0000, 10'd512, 2'd1);
        d_start = 1; step();
        run_cycles(600);
        d_stop = 1; step();
        run_cycles(4);

        // Single-cycle host write, then read it back as the 6th sample.
        d_wr_req = 1; d_wr_addr = 12'd5; d_wr_data = 8'hA5; step();
        d_wr_req = 0; run_cycles(2);
        check("ram_word5", ram[5], 8'hA5);
        set_cfg(32'h0040_0000, 10'd0, 2'd0);
        d_start = 1; step();
        run_cycles(10);
        d_stop = 1; step();
        run_cycles(4);

        // Out-of-range write is acked but suppressed; write and start together.
        d_wr_req = 1; d_wr_addr = 12'd3100; d_wr_data = 8'h5A; step();
        d_wr_req = 0; run_cycles(2);
        d_wr_req = 1; d_wr_addr = 12'd7; d_wr_data = 8'h3C; d_start = 1; step();
        d_wr_req = 0; run_cycles(10);
        d_stop = 1; step();
        run_cycles(4);

        // Write request held during RUN waits until after stop.
        d_start = 1; step();
        d_wr_req = 1; d_wr_addr = 12'd9; d_wr_data = 8'h77;
        run_cycles(12);
        d_stop = 1; step();
        run_cycles(2);
        d_wr_req = 0; run_cycles(4);

        // Tuning word change mid-run, then asynchronous reset between edges.
        set_cfg(32'h0040_0000, 10'd0, 2'd0);
        d_start = 1; step();
        run_cycles(8);
        set_cfg(32'h0100_0000, 10'd0, 2'd0);
        run_cycles(8);
        @(negedge clka);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        start = 0; stop = 0; cfg_update = 0; wr_req = 0;
        d_start = 0; d_stop = 0; d_cfg = 0; d_wr_req = 0;
        @(negedge clka);
        rst_n = 1'b1;

        // Random traffic with a well-behaved host writer.
        for (int i = 0; i < 3000; i++) begin
            if (saw_ack) begin
                d_wr_req = 0;
            end else if (!d_wr_req && $urandom_range(0, 29) == 0) begin
                d_wr_req = 1;
                d_wr_addr = 12'($urandom_range(0, 4095));
                d_wr_data = 8'($urandom);
            end
            d_start = ($urandom_range(0, 39) == 0);
            d_stop  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) begin
                d_cfg = 1;
                d_fword = $urandom;
                d_pword = 10'($urandom_range(0, 1023));
                d_wave = 2'($urandom_range(0, 3));
            end
            step();
        end

        d_wr_req = 0; d_start = 0; d_stop = 1; step();
        run_cycles(6);
        check("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
